// File: rtl/sc_backg_sequencer.sv
// +--------------------------------------------------------------------------+
// | sc_backg_sequencer: Moore background-scroll controller (lanes/lives/pause)|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module sc_backg_sequencer #(
  parameter int               LANES      = 2,
  parameter logic [LANES-1:0] LANE_DIR   = '0,
  parameter int               LIVES_INIT = 3,
  parameter int               LIVES_W    = 2,
  parameter int               CRASH_HOLD = 8,
  parameter int               HOLD_W     = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_InHigh,
  input  logic                 startButton_InLow,
  input  logic                 pauseButton_InLow,
  input  logic [LANES-1:0]     T0_InLow,
  input  logic                 crash_InLow,
  output logic                 clear_OutLow,
  output logic                 load_OutLow,
  output logic [2*LANES-1:0]   shiftselection_Out,
  output logic                 upcount_OutLow,
  output logic [LIVES_W-1:0]   lives_Out,
  output logic                 paused_OutHigh,
  output logic                 gameOver_OutHigh
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_START  = 4'd1,
    S_IDLE   = 4'd2,
    S_INIT   = 4'd3,
    S_LOAD   = 4'd4,
    S_WREL   = 4'd5,
    S_CHECK  = 4'd6,
    S_SHIFT  = 4'd7,
    S_COUNT  = 4'd8,
    S_CRASH  = 4'd9,
    S_HOLD   = 4'd10,
    S_PREL   = 4'd11,
    S_PAUSED = 4'd12,
    S_RREL   = 4'd13,
    S_LOSE   = 4'd14
  } state_t;

  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [LANES-1:0]     mask_q, mask_d;
  logic                 in_hold_q, in_hold_d;
  logic [HOLD_W-1:0]    holdoff_q, holdoff_d;

  logic                 clear_q, load_q, upcount_q, paused_q, gameover_q;
  logic [2*LANES-1:0]   sel_q;
  logic [2*LANES-1:0]   w_shift_code_d;

  logic [LANES-1:0]     w_tick;
  logic                 w_any_tick;

  assign w_tick     = ~T0_InLow;
  assign w_any_tick = |w_tick;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    mask_d    = mask_q;
    in_hold_d = in_hold_q;
    holdoff_d = holdoff_q;

    // Holdoff runs down across the whole post-crash window, including its shift/count detours.
    if (in_hold_q && (state_q == S_HOLD || state_q == S_SHIFT || state_q == S_COUNT) &&
        holdoff_q != '0)
      holdoff_d = holdoff_q - HOLD_W'(1);

    case (state_q)
      S_RESET:  state_d = S_START;
      S_START:  state_d = S_IDLE;
      S_IDLE:   if (!startButton_InLow) state_d = S_INIT;
      S_INIT: begin
        lives_d   = LIVES_W'(LIVES_INIT);
        in_hold_d = 1'b0;
        state_d   = S_LOAD;
      end
      S_LOAD:   state_d = S_WREL;
      S_WREL:   if (startButton_InLow) state_d = S_CHECK;
      S_CHECK: begin
        if (!startButton_InLow)      state_d = S_INIT;
        else if (!crash_InLow)       state_d = S_CRASH;
        else if (!pauseButton_InLow) state_d = S_PREL;
        else if (w_any_tick) begin
          state_d = S_SHIFT;
          mask_d  = w_tick;
        end
        else                         state_d = S_COUNT;
      end
      S_SHIFT:  state_d = S_COUNT;
      S_COUNT:  state_d = in_hold_q ? S_HOLD : S_CHECK;
      S_CRASH: begin
        lives_d = (lives_q != '0) ? lives_q - LIVES_W'(1) : '0;
        if (lives_q <= LIVES_W'(1)) begin
          state_d = S_LOSE;
        end else begin
          state_d   = S_HOLD;
          in_hold_d = 1'b1;
          holdoff_d = HOLD_W'(CRASH_HOLD - 1);
        end
      end
      S_HOLD: begin
        if (holdoff_q == '0) begin
          state_d   = S_CHECK;
          in_hold_d = 1'b0;
        end else if (w_any_tick) begin
          state_d = S_SHIFT;
          mask_d  = w_tick;
        end else begin
          state_d = S_COUNT;
        end
      end
      S_PREL:   if (pauseButton_InLow) state_d = S_PAUSED;
      S_PAUSED: begin
        if (!startButton_InLow)      state_d = S_INIT;
        else if (!pauseButton_InLow) state_d = S_RREL;
      end
      S_RREL:   if (pauseButton_InLow) state_d = S_CHECK;
      S_LOSE:   if (!startButton_InLow) state_d = S_INIT;
      default:  state_d = S_RESET;
    endcase
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_shift_code_d[2*i +: 2] = !mask_d[i] ? 2'b11 :
                                      (LANE_DIR[i] ? 2'b01 : 2'b10);
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      state_q    <= S_RESET;
      lives_q    <= '0;
      mask_q     <= '0;
      in_hold_q  <= 1'b0;
      holdoff_q  <= '0;
      clear_q    <= 1'b1;
      load_q     <= 1'b1;
      sel_q      <= '1;
      upcount_q  <= 1'b1;
      paused_q   <= 1'b0;
      gameover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      mask_q     <= mask_d;
      in_hold_q  <= in_hold_d;
      holdoff_q  <= holdoff_d;
      clear_q    <= !(state_d == S_INIT || state_d == S_CRASH || state_d == S_LOSE);
      load_q     <= (state_d != S_LOAD);
      sel_q      <= (state_d == S_LOAD)  ? '0 :
                    (state_d == S_SHIFT) ? w_shift_code_d : '1;
      upcount_q  <= (state_d != S_COUNT);
      paused_q   <= (state_d == S_PREL || state_d == S_PAUSED || state_d == S_RREL);
      gameover_q <= (state_d == S_LOSE);
    end
  end

  assign clear_OutLow       = clear_q;
  assign load_OutLow        = load_q;
  assign shiftselection_Out = sel_q;
  assign upcount_OutLow     = upcount_q;
  assign lives_Out          = lives_q;
  assign paused_OutHigh     = paused_q;
  assign gameOver_OutHigh   = gameover_q;

endmodule

`default_nettype wire
